parse_stream: RTL
=================

# parse_stream

Streaming, parametrised instruction parser for the network-programming path. It accepts instruction words over a valid/ready handshake, buffers them in a small FIFO, and splits each word into opcode, activation, dense and cost fields. For selected opcodes it binds the following word as an immediate operand, and it flags illegal opcodes. It sits between the instruction source and the layer/cost execution units, and replaces the single-word, clock-echo parser. All downstream flow is valid/ready; there is no echoed clock.

## Interface
- OP_W, default 4: opcode field width.
- PA_W, default 4: param A width (activation type).
- PB_W, default 4: param B width (dense type).
- DEPTH, default 4: input FIFO depth in words. Must be ≥2 and a power of two.
- LONG_OP_MASK, default 16'h8000, width 2**OP_W: bit k set means opcode k consumes a second word as its immediate.
- VALID_OP_MASK, default 16'h807F, width 2**OP_W: bit k set means opcode k is legal.
- Derived: CW = OP_W+PA_W+PB_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- code  in  CW  instruction word.
- code_valid  in  1  code is presented.
- code_ready  out  1  FIFO can accept a word.
- op  out  OP_W  opcode, code[CW-1 -: OP_W].
- act_type  out  PA_W  code[PA_W+PB_W-1 -: PA_W].
- dense_type  out  PB_W  code[PB_W-1:0].
- cost_type  out  PA_W+PB_W  code[PA_W+PB_W-1:0].
- imm  out  CW  immediate word; 0 for short opcodes.
- illegal  out  1  opcode not in VALID_OP_MASK.
- dec_valid  out  1  decoded instruction is presented.
- dec_ready  in  1  consumer accepts it.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- A push occurs when code_valid && code_ready.
- code_ready = !rst && (fifo_count < DEPTH). There is no push-through when full.
- FSM states:
  - S_OP: waiting for a first word.
  - S_IMM: first word latched, waiting for its immediate.
  - S_OUT: output held.
- S_OP, FIFO non-empty: pop the word and register all fields.
  - If LONG_OP_MASK[op] is set, go to S_IMM.
  - Otherwise set imm=0 and dec_valid=1, and go to S_OUT.
- S_IMM, FIFO non-empty: pop the word into imm, set dec_valid=1, go to S_OUT.
- S_OUT: all outputs hold stable while dec_valid && !dec_ready.
  - On dec_ready with FIFO non-empty: pop the next word in the same cycle and behave as S_OP does. This gives back-to-back short instructions at 1 per cycle.
  - On dec_ready with FIFO empty: dec_valid=0, go to S_OP.
- Illegal opcode: illegal=1 alongside dec_valid. Fields are still decoded. The instruction is always treated as short, even if its LONG_OP_MASK bit is set.
- Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.

## Timing
- Reset: all field outputs, imm, illegal, dec_valid, fifo_count = 0. code_ready=0 during rst. State = S_OP. FIFO is emptied.
- Short-instruction latency: word pushed at edge t with FSM in S_OP and FIFO empty → dec_valid=1 after edge t+1.
- Long instruction: dec_valid=1 one edge after the immediate's push edge, if the FSM is already in S_IMM.
- Throughput is 1 short instruction per cycle with dec_ready held high. Long instructions take 2 cycles each.
- rst asserted mid-instruction (in S_IMM or S_OUT): the partial or held instruction is discarded. The first word after reset is always parsed as an opcode word.
- dec_valid never drops without a handshake, except under rst.

## Structure
- Package parse_pkg holds:
  - the state enum (S_OP, S_IMM, S_OUT);
  - default width localparams;
  - a struct for decoded fields;
  - field-extraction functions shared with the execution units.
- Sub-module sync_fifo (parameters WIDTH, DEPTH), providing push, pop, count, full and empty. The parser FSM, decode and output registers live in parse_stream.

## Test plan
- Reset then push 12'h3A5 → after edge t+1: op=3, act_type=A, dense_type=5, cost_type=A5, imm=0, illegal=0, dec_valid=1.
- Push 12'hF12 then 12'hBEE, with a 3-cycle gap between them → op=F, act_type=1, dense_type=2, imm=BEE. dec_valid stays 0 during the gap.
- Push 12'h9AB → dec_valid=1, illegal=1, op=9. The next word 12'h100 is parsed as an opcode (op=1), not as an immediate.
- dec_ready=0, push 5 words → fifo_count reaches 4 with code_ready=0. Then hold dec_ready=1 → all words emerge in order at 1 per cycle, nothing is lost, and fields are stable while stalled.
- Assert rst for 1 cycle after pushing 12'hF00 without its immediate → dec_valid=0 and fifo_count=0. A following 12'h245 decodes as op=2.
- Continuous push with dec_ready=1 and random gaps: simultaneous push/pop at fifo_count=2 keeps the count at 2. The output stream matches a reference model.

Source files
------------

// File: rtl/parse_pkg.sv
// rtl/parse_pkg.sv - shared state enum, default widths, decoded-field type and field helpers for the instruction parser
package parse_pkg;

    localparam int DEF_OP_W  = 4;
    localparam int DEF_PA_W  = 4;
    localparam int DEF_PB_W  = 4;
    localparam int DEF_CW    = DEF_OP_W + DEF_PA_W + DEF_PB_W;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        S_OP  = 2'd0,
        S_IMM = 2'd1,
        S_OUT = 2'd2
    } parse_state_t;

    typedef struct packed {
        logic [DEF_OP_W-1:0] op;
        logic [DEF_PA_W-1:0] act_type;
        logic [DEF_PB_W-1:0] dense_type;
        logic [DEF_CW-1:0]   imm;
        logic                illegal;
    } dec_word_t;

    // Generic bitfield pick so every unit slices instruction words the same way.
    function automatic logic [31:0] field_of(input logic [31:0] word, input int lsb, input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (word >> lsb) & mask;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with first-word fall-through read data
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/parse_stream.sv
// rtl/parse_stream.sv - buffered instruction parser: splits words into fields and binds immediates to long opcodes
module parse_stream
    import parse_pkg::*;
#(
    parameter int OP_W  = DEF_OP_W,
    parameter int PA_W  = DEF_PA_W,
    parameter int PB_W  = DEF_PB_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter logic [2**OP_W-1:0] LONG_OP_MASK  = 16'h8000,
    parameter logic [2**OP_W-1:0] VALID_OP_MASK = 16'h807F,
    localparam int CW    = OP_W + PA_W + PB_W,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CW-1:0]        code,
    input  logic                 code_valid,
    output logic                 code_ready,
    output logic [OP_W-1:0]      op,
    output logic [PA_W-1:0]      act_type,
    output logic [PB_W-1:0]      dense_type,
    output logic [PA_W+PB_W-1:0] cost_type,
    output logic [CW-1:0]        imm,
    output logic                 illegal,
    output logic                 dec_valid,
    input  logic                 dec_ready,
    output logic [CNT_W-1:0]     fifo_count
);

    logic [CW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;

    parse_state_t    state, state_n;
    logic [OP_W-1:0] op_q, op_n;
    logic [PA_W-1:0] act_q, act_n;
    logic [PB_W-1:0] dense_q, dense_n;
    logic [CW-1:0]   imm_q, imm_n;
    logic            illegal_q, illegal_n;
    logic            valid_q, valid_n;

    logic [OP_W-1:0] w_op;
    logic [PA_W-1:0] w_act;
    logic [PB_W-1:0] w_dense;
    logic            w_illegal;
    logic            w_long;
    logic            take_op;

    assign code_ready = !rst && !fifo_full;
    assign fifo_push  = code_valid && code_ready;

    sync_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (code),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign w_op      = OP_W'(field_of(32'(fifo_dout), PA_W + PB_W, OP_W));
    assign w_act     = PA_W'(field_of(32'(fifo_dout), PB_W, PA_W));
    assign w_dense   = PB_W'(field_of(32'(fifo_dout), 0, PB_W));
    assign w_illegal = !VALID_OP_MASK[w_op];
    // An illegal opcode never claims the next word, whatever its long bit says.
    assign w_long    = LONG_OP_MASK[w_op] && !w_illegal;

    always_comb begin
        state_n   = state;
        op_n      = op_q;
        act_n     = act_q;
        dense_n   = dense_q;
        imm_n     = imm_q;
        illegal_n = illegal_q;
        valid_n   = valid_q;
        fifo_pop  = 1'b0;
        take_op   = 1'b0;

        case (state)
            S_OP: take_op = !fifo_empty;
            S_IMM: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    imm_n    = fifo_dout;
                    valid_n  = 1'b1;
                    state_n  = S_OUT;
                end
            end
            S_OUT: begin
                if (dec_ready) begin
                    if (!fifo_empty) begin
                        take_op = 1'b1;
                    end else begin
                        valid_n = 1'b0;
                        state_n = S_OP;
                    end
                end
            end
            default: state_n = S_OP;
        endcase

        // Opcode-word load shared by the idle state and the handshake-and-reload path.
        if (take_op) begin
            fifo_pop  = 1'b1;
            op_n      = w_op;
            act_n     = w_act;
            dense_n   = w_dense;
            illegal_n = w_illegal;
            imm_n     = '0;
            if (w_long) begin
                valid_n = 1'b0;
                state_n = S_IMM;
            end else begin
                valid_n = 1'b1;
                state_n = S_OUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_OP;
            op_q      <= '0;
            act_q     <= '0;
            dense_q   <= '0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state     <= state_n;
            op_q      <= op_n;
            act_q     <= act_n;
            dense_q   <= dense_n;
            imm_q     <= imm_n;
            illegal_q <= illegal_n;
            valid_q   <= valid_n;
        end
    end

    assign op         = op_q;
    assign act_type   = act_q;
    assign dense_type = dense_q;
    assign cost_type  = {act_q, dense_q};
    assign imm        = imm_q;
    assign illegal    = illegal_q;
    assign dec_valid  = valid_q;

endmodule
